// File: rtl/aes_issue_stager.sv
// aes_issue_stager
// Staging stage in front of the AES encoder pipeline. It buffers
// {plaintext, key, last} records in a small FIFO. It issues at most one
// record per cycle into the non-stallable encoder, and only while
// downstream result credits are available. A tag shift register matches the
// encoder latency, so it can flag which encoder output cycles carry real
// results and which one carries the end of a message.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake; in_ready is a pure register
//   in_data, in_key         128-bit plaintext state and cipher key
//   in_last                 record closes the current message
//   enc_data, enc_key       registered encoder inputs (zero when idle)
//   enc_issue               enc_data/enc_key carry a real record
//   res_valid, res_last     encoder output this cycle is real / is the last
//   credit_return           downstream freed one result slot
//   done                    one-cycle pulse once a message has fully drained
//   err_credit              sticky credit-overflow flag
module aes_issue_stager #(
  parameter int DEPTH       = 4,
  parameter int ENC_LATENCY = 11,
  parameter int CREDITS     = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic [127:0] enc_data,
  output logic [127:0] enc_key,
  output logic         enc_issue,
  output logic         res_valid,
  output logic         res_last,
  input  logic         credit_return,
  output logic         done,
  output logic         err_credit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CreditsMax = CW'(CREDITS);

  typedef enum logic [1:0] {OPEN, DRAIN, DONE} state_e;

  state_e                 state_q;
  logic                   inReady_q;
  logic                   done_q;
  logic [127:0]           dataMem_q [DEPTH];
  logic [127:0]           keyMem_q  [DEPTH];
  logic [DEPTH-1:0]       lastMem_q;
  logic [AW:0]            wrPtr_q, wrPtr_d;
  logic [AW:0]            rdPtr_q, rdPtr_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic                   errCredit_q;
  logic [127:0]           encData_q, encKey_q;
  logic                   encIssue_q;
  logic [ENC_LATENCY-1:0] tagValid_q, tagLast_q;
  logic                   resValid_q, resLast_q;

  logic fifoEmpty, fullNext, push, pop, creditOverflow;

  // The extra wrap bit tells full apart from empty when the low bits match.
  assign fifoEmpty      = (wrPtr_q == rdPtr_q);
  assign push           = in_valid && inReady_q;
  assign pop            = !fifoEmpty && (credits_q != '0);
  assign creditOverflow = credit_return && !pop && (credits_q == CreditsMax);

  // Next pointers and credits. in_ready is registered from the post-edge
  // occupancy, so it drops right after the edge that fills the FIFO.
  always_comb begin
    wrPtr_d   = wrPtr_q + {{AW{1'b0}}, push};
    rdPtr_d   = rdPtr_q + {{AW{1'b0}}, pop};
    credits_d = credits_q;
    if (pop && !credit_return) begin
      credits_d = credits_q - CW'(1);
    end else if (credit_return && !pop && !creditOverflow) begin
      credits_d = credits_q + CW'(1);
    end
  end

  assign fullNext = (wrPtr_d[AW] != rdPtr_d[AW]) &&
                    (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]);

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      dataMem_q[wrPtr_q[AW-1:0]] <= in_data;
      keyMem_q[wrPtr_q[AW-1:0]]  <= in_key;
      lastMem_q[wrPtr_q[AW-1:0]] <= in_last;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      credits_q   <= CreditsMax;
      errCredit_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      credits_q <= credits_d;
      if (creditOverflow) begin
        errCredit_q <= 1'b1;
      end
    end
  end

  // Issue register and tag pipeline. Tag stage 0 loads on the same edge as
  // enc_data, and res_* is one more register after the final stage, so the
  // flags line up with the encoder output ENC_LATENCY cycles later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      encData_q  <= '0;
      encKey_q   <= '0;
      encIssue_q <= 1'b0;
      tagValid_q <= '0;
      tagLast_q  <= '0;
      resValid_q <= 1'b0;
      resLast_q  <= 1'b0;
    end else begin
      encIssue_q    <= pop;
      encData_q     <= pop ? dataMem_q[rdPtr_q[AW-1:0]] : '0;
      encKey_q      <= pop ? keyMem_q[rdPtr_q[AW-1:0]] : '0;
      tagValid_q[0] <= pop;
      tagLast_q[0]  <= pop && lastMem_q[rdPtr_q[AW-1:0]];
      for (int i = 1; i < ENC_LATENCY; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagLast_q[i]  <= tagLast_q[i-1];
      end
      resValid_q <= tagValid_q[ENC_LATENCY-1];
      resLast_q  <= tagValid_q[ENC_LATENCY-1] && tagLast_q[ENC_LATENCY-1];
    end
  end

  // Message FSM. A record with in_last closes intake. DRAIN waits for the
  // FIFO and every tag stage to empty. DONE pulses done for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= OPEN;
      inReady_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        OPEN: begin
          if (push && in_last) begin
            state_q   <= DRAIN;
            inReady_q <= 1'b0;
          end else begin
            inReady_q <= !fullNext;
          end
        end
        DRAIN: begin
          inReady_q <= 1'b0;
          if (fifoEmpty && (tagValid_q == '0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= OPEN;
          inReady_q <= !fullNext;
        end
        default: begin
          state_q   <= OPEN;
          inReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = inReady_q;
  assign enc_data   = encData_q;
  assign enc_key    = encKey_q;
  assign enc_issue  = encIssue_q;
  assign res_valid  = resValid_q;
  assign res_last   = resLast_q;
  assign done       = done_q;
  assign err_credit = errCredit_q;

endmodule

// File: tb/tb_aes_issue_stager.sv
// tb_aes_issue_stager
// Self-checking bench for aes_issue_stager with default parameters.
// It runs a table of per-cycle vectors for a single-record message. It then
// runs hand-written sequences (streaming, credit stall, FIFO wrap, credit
// overflow, reset mid-drain). These sequences are checked every cycle against
// a small behavioural model of the FIFO, credits, tags and done timing.
module tb_aes_issue_stager;

  localparam int DEPTH   = 4;
  localparam int LAT     = 11;
  localparam int CREDITS = 4;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         in_last;
  logic [127:0] enc_data;
  logic [127:0] enc_key;
  logic         enc_issue;
  logic         res_valid;
  logic         res_last;
  logic         credit_return;
  logic         done;
  logic         err_credit;

  aes_issue_stager #(.DEPTH(DEPTH), .ENC_LATENCY(LAT), .CREDITS(CREDITS)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_last(in_last),
    .enc_data(enc_data), .enc_key(enc_key), .enc_issue(enc_issue),
    .res_valid(res_valid), .res_last(res_last),
    .credit_return(credit_return), .done(done), .err_credit(err_credit)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic [127:0] k;
    logic         l;
    logic         cr;
    logic         expReady;
    logic         expIssue;
    logic [127:0] expData;
    logic [127:0] expKey;
    logic         expRv;
    logic         expRl;
    logic         expDone;
    logic         expErr;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic [127:0] k;
    logic         l;
  } rec_t;

  typedef struct {
    int   due;
    logic last;
  } tag_t;

  int    nTests = 0;
  int    nFail  = 0;
  int    nIssue, nRes, nLast;
  string phase;
  logic  acc;

  // Reference model state, valid as of the most recent rising edge.
  rec_t  mq[$];
  tag_t  pend[$];
  int    mCred;
  logic  mErr, mOpen, reopen;
  int    cyc, doneDue;

  vec_t  vecs[16];

  localparam logic [127:0] BasicData = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BasicKey  = 128'h000102030405060708090a0b0c0d0e0f;

  function automatic logic [127:0] mkData(input int i);
    return {4{32'hDA7A_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] mkKey(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Assert reset mid-cycle, confirm every output clears at once, then release
  // on a falling edge. Returns aligned 1 time unit after a rising edge.
  task automatic doReset(input string tag);
    in_valid = 1'b0; in_data = '0; in_key = '0; in_last = 1'b0;
    credit_return = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput({tag, "_in_ready"},   in_ready,   0);
    checkOutput({tag, "_enc_issue"},  enc_issue,  0);
    checkOutput({tag, "_enc_data"},   enc_data,   0);
    checkOutput({tag, "_enc_key"},    enc_key,    0);
    checkOutput({tag, "_res_valid"},  res_valid,  0);
    checkOutput({tag, "_res_last"},   res_last,   0);
    checkOutput({tag, "_done"},       done,       0);
    checkOutput({tag, "_err_credit"}, err_credit, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    mq.delete(); pend.delete();
    mCred = CREDITS; mErr = 1'b0; mOpen = 1'b1; reopen = 1'b0;
    cyc = 0; doneDue = -1;
  endtask

  // One clock cycle of stimulus. The model predicts this cycle's handshake
  // and issue, then all outputs after the edge are compared.
  task automatic applyStimulus(input logic v, input logic [127:0] d,
                               input logic [127:0] k, input logic l,
                               input logic cr, output logic accepted);
    logic expReady, iss, expRv, expRl, expDone;
    rec_t head;
    head = '{d: '0, k: '0, l: 1'b0};
    expReady = mOpen && (mq.size() < DEPTH);
    checkOutput({phase, "_in_ready"}, in_ready, expReady);
    accepted = v && expReady;
    iss = (mq.size() > 0) && (mCred > 0);
    in_valid = v; in_data = d; in_key = k; in_last = l; credit_return = cr;
    @(posedge clock);
    #1;
    cyc++;
    if (iss) head = mq.pop_front();
    if (accepted) mq.push_back('{d: d, k: k, l: l});
    if (iss && !cr) mCred--;
    else if (cr && !iss) begin
      if (mCred == CREDITS) mErr = 1'b1;
      else mCred++;
    end
    if (accepted && l) mOpen = 1'b0;
    if (reopen) begin
      mOpen = 1'b1;
      reopen = 1'b0;
    end
    expRv = (pend.size() > 0) && (pend[0].due == cyc);
    expRl = 1'b0;
    if (expRv) begin
      expRl = pend[0].last;
      void'(pend.pop_front());
      if (expRl) doneDue = cyc + 1;
    end
    if (iss) pend.push_back('{due: cyc + LAT, last: head.l});
    expDone = (cyc == doneDue);
    if (expDone) reopen = 1'b1;
    checkOutput({phase, "_enc_issue"},  enc_issue,  iss);
    checkOutput({phase, "_enc_data"},   enc_data,   head.d);
    checkOutput({phase, "_enc_key"},    enc_key,    head.k);
    checkOutput({phase, "_res_valid"},  res_valid,  expRv);
    checkOutput({phase, "_res_last"},   res_last,   expRl);
    checkOutput({phase, "_done"},       done,       expDone);
    checkOutput({phase, "_err_credit"}, err_credit, mErr);
    nIssue += int'(enc_issue);
    nRes   += int'(res_valid);
    nLast  += int'(res_last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, 0, acc);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0;
    in_last = 1'b0; credit_return = 1'b0;
    nIssue = 0; nRes = 0; nLast = 0;
    #2;
    doReset("reset0");
    checkOutput("reset0_release_in_ready", in_ready, 1);

    // Basic record, per-cycle table. The record is accepted at edge 0 and
    // issued at edge 1. res_valid/res_last show after edge 12 (1 + 11),
    // done after edge 13, and intake reopens after edge 14. The credit
    // return at edge 2 refills the slot taken by the issue.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{v: 0, d: '0, k: '0, l: 0, cr: 0, expReady: 0, expIssue: 0,
                  expData: '0, expKey: '0, expRv: 0, expRl: 0, expDone: 0,
                  expErr: 0};
    end
    vecs[0].v = 1; vecs[0].d = BasicData; vecs[0].k = BasicKey; vecs[0].l = 1;
    vecs[1].expIssue = 1; vecs[1].expData = BasicData; vecs[1].expKey = BasicKey;
    vecs[2].cr = 1;
    vecs[12].expRv = 1; vecs[12].expRl = 1;
    vecs[13].expDone = 1;
    vecs[14].expReady = 1;
    vecs[15].expReady = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = vecs[i].v; in_data = vecs[i].d; in_key = vecs[i].k;
      in_last = vecs[i].l; credit_return = vecs[i].cr;
      @(posedge clock);
      #1;
      checkOutput($sformatf("basic_v%0d_in_ready", i),   in_ready,   vecs[i].expReady);
      checkOutput($sformatf("basic_v%0d_enc_issue", i),  enc_issue,  vecs[i].expIssue);
      checkOutput($sformatf("basic_v%0d_enc_data", i),   enc_data,   vecs[i].expData);
      checkOutput($sformatf("basic_v%0d_enc_key", i),    enc_key,    vecs[i].expKey);
      checkOutput($sformatf("basic_v%0d_res_valid", i),  res_valid,  vecs[i].expRv);
      checkOutput($sformatf("basic_v%0d_res_last", i),   res_last,   vecs[i].expRl);
      checkOutput($sformatf("basic_v%0d_done", i),       done,       vecs[i].expDone);
      checkOutput($sformatf("basic_v%0d_err_credit", i), err_credit, vecs[i].expErr);
    end

    // Streaming: 8 back-to-back records with a credit back on every issue.
    doReset("reset1");
    phase = "stream";
    nIssue = 0; nRes = 0; nLast = 0;
    for (int i = 0; i < 23; i++) begin
      applyStimulus(i < 8, mkData(i), mkKey(i), i == 7, (i >= 1) && (i <= 8), acc);
    end
    checkOutput("stream_issue_count", nIssue, 8);
    checkOutput("stream_res_count", nRes, 8);
    checkOutput("stream_last_count", nLast, 1);

    // Credit stall: 6 records with no credits back, so only 4 issue.
    doReset("reset2");
    phase = "stall";
    nIssue = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1, mkData(10 + i), mkKey(10 + i), 0, 0, acc);
    idle(3);
    checkOutput("stall_issue_count", nIssue, 4);
    applyStimulus(0, '0, '0, 0, 1, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
    idle(2);
    checkOutput("stall_one_more_issue", nIssue, 5);

    // Full/wrap: fill to DEPTH with no credits, offer a rejected record,
    // then drain and refill three times across the pointer wrap.
    phase = "wrap";
    nIssue = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, mkData(20 + i), mkKey(20 + i), 0, 0, acc);
    applyStimulus(1, mkData(99), mkKey(99), 0, 0, acc);
    checkOutput("wrap_full_rejects", in_ready, 0);
    for (int rep = 0; rep < 3; rep++) begin
      int n;
      for (int t = 0; t < 6; t++) applyStimulus(0, '0, '0, 0, mCred < CREDITS, acc);
      n = 0;
      for (int t = 0; t < 12 && n < 4; t++) begin
        applyStimulus(1, mkData(30 + rep * 4 + n), mkKey(30 + rep * 4 + n), 0, 0, acc);
        if (acc) n++;
      end
    end
    for (int t = 0; t < 8; t++) applyStimulus(0, '0, '0, 0, mCred < CREDITS, acc);
    idle(2);
    checkOutput("wrap_total_issues", nIssue, 16);

    // Credit overflow: a return at full count sets the sticky flag and
    // leaves the count at CREDITS, so only 4 of 5 records issue.
    doReset("reset3");
    phase = "ovf";
    applyStimulus(0, '0, '0, 0, 1, acc);
    idle(3);
    nIssue = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1, mkData(60 + i), mkKey(60 + i), 0, 0, acc);
    idle(3);
    checkOutput("ovf_issue_count", nIssue, 4);
    checkOutput("ovf_flag_sticky", err_credit, 1);

    // Reset mid-drain with two tags in flight; the flag clears, no stale
    // result is flagged, and the full credit count is restored.
    doReset("reset4");
    phase = "middrain";
    applyStimulus(1, mkData(70), mkKey(70), 0, 0, acc);
    applyStimulus(1, mkData(71), mkKey(71), 1, 0, acc);
    applyStimulus(0, '0, '0, 0, 0, acc);
    checkOutput("middrain_issue_before_reset", enc_issue, 1);
    doReset("reset5");
    phase = "postrst";
    checkOutput("postrst_in_ready", in_ready, 1);
    nRes = 0;
    idle(15);
    checkOutput("postrst_no_stale_res", nRes, 0);
    nIssue = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1, mkData(80 + i), mkKey(80 + i), 0, 0, acc);
    idle(3);
    checkOutput("postrst_credit_count", nIssue, 4);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
